// File: rtl/ddr_dimm_responder.sv
// ddr_dimm_responder
//   DRAM-side command/data engine of the DIMM model. It decodes DDR4 commands
//   from the controller and keeps a per-bank open-row table. Read bursts are
//   returned after AL+CL, and write bursts are captured after AL+CWL into a
//   behavioural array. Data moves two beats per clock as {fall,rise}, so a BL8
//   burst occupies 4 clocks.
//
// Ports
//   clock, reset_n           controller clock, asynchronous active-low reset
//   cs_n, act_n, ras_n,
//   cas_n, we_n              DDR4 command pins (ras/cas/we double as A16..A14)
//   bg, ba                   bank group / bank address (bank = {bg,ba})
//   addr                     row (ACT) or column (RD/WR) address, addr[10] = PRE all
//   dq_in                    write data {fall,rise}
//   dq_out, dq_oe            read data {fall,rise} and its drive enable
//   dqs_oe                   read strobe enable, including the read preamble
//   wr_done                  one-clock pulse after the last write beat is stored
//   cmd_err                  one-clock pulse on an illegal or colliding command
module ddr_dimm_responder #(
    parameter int tCAS_R   = 13,
    parameter int tCAS_W   = 10,
    parameter int AL_DLY   = 0,
    parameter int R_PRE    = 1,
    parameter int W_PRE    = 1,
    parameter int DQ_W     = 8,
    parameter int ROW_BITS = 4,
    parameter int COL_BITS = 7
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                cs_n,
    input  logic                act_n,
    input  logic                ras_n,
    input  logic                cas_n,
    input  logic                we_n,
    input  logic [1:0]          bg,
    input  logic [1:0]          ba,
    input  logic [17:0]         addr,
    input  logic [2*DQ_W-1:0]   dq_in,
    output logic [2*DQ_W-1:0]   dq_out,
    output logic                dq_oe,
    output logic                dqs_oe,
    output logic                wr_done,
    output logic                cmd_err
);

    localparam int LAT_R  = AL_DLY + tCAS_R;
    localparam int LAT_W  = AL_DLY + tCAS_W;
    localparam int DEPTH  = AL_DLY + ((tCAS_R > tCAS_W) ? tCAS_R : tCAS_W) + 4;
    localparam int BASE_W = 4 + ROW_BITS + COL_BITS - 3;
    localparam int AW     = BASE_W + 3;

    // Data clocks a new command would occupy, relative to the command clock.
    localparam logic [DEPTH-1:0] RD_WIN = DEPTH'(4'hF) << LAT_R;
    localparam logic [DEPTH-1:0] WR_WIN = DEPTH'(4'hF) << LAT_W;

    logic [DQ_W-1:0]        mem [2**AW];
    logic [15:0]            bank_open;
    logic [ROW_BITS-1:0]    bank_row [16];

    // After clock e, bit i of *_occ / *_start describes clock e+1+i.
    logic [DEPTH-1:0]       rd_occ, wr_occ, rd_start, wr_start;
    logic [BASE_W-1:0]      rd_sbase [DEPTH];
    logic [BASE_W-1:0]      wr_sbase [DEPTH];

    logic [7:0][DQ_W-1:0]   rd_buf;
    logic [7:0][DQ_W-1:0]   launch_beats;
    logic [1:0]             rd_cnt;
    logic                   rd_act;
    logic [BASE_W-1:0]      wr_base;
    logic [2:0]             wr_cnt;

    logic [3:0]             bank;
    logic                   is_act, is_rd, is_wr, is_pre;
    logic                   coll_r, coll_w, rd_ok, wr_ok;
    logic [BASE_W-1:0]      cur_base;
    logic                   wr_en;
    logic [AW-1:0]          wr_idx;
    logic                   unused_bits;

    assign unused_bits = ^addr ^ (W_PRE != 0);

    assign bank   = {bg, ba};
    assign is_act = !cs_n && !act_n;
    assign is_rd  = !cs_n && act_n && ras_n && !cas_n && we_n;
    assign is_wr  = !cs_n && act_n && ras_n && !cas_n && !we_n;
    assign is_pre = !cs_n && act_n && !ras_n && cas_n && !we_n;

    assign coll_r   = |((rd_occ | wr_occ) & RD_WIN);
    assign coll_w   = |((rd_occ | wr_occ) & WR_WIN);
    assign rd_ok    = is_rd && bank_open[bank] && !coll_r;
    assign wr_ok    = is_wr && bank_open[bank] && !coll_w;
    assign cur_base = {bank, bank_row[bank], addr[COL_BITS-1:3]};

    // Read data is taken from the array on the burst's first data clock.
    always_comb begin
        launch_beats = '0;
        for (int unsigned j = 0; j < 8; j++) begin
            launch_beats[j] = mem[{rd_sbase[0], 3'(j)}];
        end
    end

    always_comb begin
        wr_en  = 1'b0;
        wr_idx = '0;
        if (wr_start[0]) begin
            wr_en  = 1'b1;
            wr_idx = {wr_sbase[0], 3'b000};
        end else if (wr_cnt inside {3'd1, 3'd2, 3'd3}) begin
            wr_en  = 1'b1;
            wr_idx = {wr_base, wr_cnt[1:0], 1'b0};
        end
    end

    // Storage that is deliberately not reset: array, rows, burst addresses.
    always_ff @(posedge clock) begin
        for (int unsigned i = 0; i < DEPTH - 1; i++) begin
            rd_sbase[i] <= rd_sbase[i+1];
            wr_sbase[i] <= wr_sbase[i+1];
        end
        if (rd_ok) rd_sbase[LAT_R-1] <= cur_base;
        if (wr_ok) wr_sbase[LAT_W-1] <= cur_base;
        if (is_act && !bank_open[bank]) bank_row[bank] <= addr[ROW_BITS-1:0];
        if (wr_en) begin
            mem[wr_idx]                <= dq_in[DQ_W-1:0];
            mem[{wr_idx[AW-1:1], 1'b1}] <= dq_in[2*DQ_W-1:DQ_W];
        end
        if (wr_start[0]) wr_base <= wr_sbase[0];
        if (rd_start[0]) rd_buf  <= launch_beats;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bank_open <= '0;
            rd_occ    <= '0;
            wr_occ    <= '0;
            rd_start  <= '0;
            wr_start  <= '0;
            rd_cnt    <= '0;
            rd_act    <= 1'b0;
            wr_cnt    <= '0;
            dq_out    <= '0;
            dq_oe     <= 1'b0;
            dqs_oe    <= 1'b0;
            wr_done   <= 1'b0;
            cmd_err   <= 1'b0;
        end else begin
            if (is_act && !bank_open[bank]) bank_open[bank] <= 1'b1;
            if (is_pre) begin
                if (addr[10]) bank_open <= '0;
                else          bank_open[bank] <= 1'b0;
            end
            cmd_err <= (is_act && bank_open[bank]) || (is_rd && !rd_ok) || (is_wr && !wr_ok);

            // Windows are shifted one step as they are inserted.
            rd_occ   <= (rd_occ >> 1) | (rd_ok ? (RD_WIN >> 1) : '0);
            wr_occ   <= (wr_occ >> 1) | (wr_ok ? (WR_WIN >> 1) : '0);
            rd_start <= (rd_start >> 1) | (rd_ok ? (DEPTH'(1) << (LAT_R - 1)) : '0);
            wr_start <= (wr_start >> 1) | (wr_ok ? (DEPTH'(1) << (LAT_W - 1)) : '0);

            if (rd_start[0]) begin
                dq_out <= {launch_beats[1], launch_beats[0]};
                dq_oe  <= 1'b1;
                rd_act <= 1'b1;
                rd_cnt <= 2'd1;
            end else if (rd_act) begin
                dq_out <= {rd_buf[{rd_cnt, 1'b1}], rd_buf[{rd_cnt, 1'b0}]};
                dq_oe  <= 1'b1;
                rd_cnt <= rd_cnt + 2'd1;
                rd_act <= (rd_cnt != 2'd3);
            end else begin
                dq_out <= '0;
                dq_oe  <= 1'b0;
            end
            dqs_oe <= rd_occ[0] | ((R_PRE != 0) & rd_occ[1]);

            wr_done <= (wr_cnt == 3'd4);
            if (wr_start[0])                          wr_cnt <= 3'd1;
            else if (wr_cnt inside {3'd1, 3'd2, 3'd3}) wr_cnt <= wr_cnt + 3'd1;
            else                                      wr_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_ddr_dimm_responder.sv
module tb_ddr_dimm_responder;

    localparam int K_ACT = 0;
    localparam int K_RD  = 1;
    localparam int K_WR  = 2;
    localparam int K_PRE = 3;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        cs_n = 1'b1, cs2_n = 1'b1;
    logic        act_n = 1'b1, ras_n = 1'b1, cas_n = 1'b1, we_n = 1'b1;
    logic [1:0]  bg = '0, ba = '0;
    logic [17:0] addr = '0;
    logic [15:0] dq_in = '0;
    logic [15:0] dq_out, dq2_out;
    logic        dq_oe, dqs_oe, wr_done, cmd_err;
    logic        dq2_oe, dqs2_oe, wr2_done, cmd2_err;

    int total = 0;
    int bad = 0;

    logic [15:0] exp_a [4];
    logic [15:0] exp_b [4];

    always #5 clock = ~clock;

    ddr_dimm_responder u_dut (
        .clock(clock), .reset_n(reset_n), .cs_n(cs_n), .act_n(act_n),
        .ras_n(ras_n), .cas_n(cas_n), .we_n(we_n), .bg(bg), .ba(ba),
        .addr(addr), .dq_in(dq_in), .dq_out(dq_out), .dq_oe(dq_oe),
        .dqs_oe(dqs_oe), .wr_done(wr_done), .cmd_err(cmd_err)
    );

    ddr_dimm_responder #(.AL_DLY(2), .R_PRE(0)) u_dut_al (
        .clock(clock), .reset_n(reset_n), .cs_n(cs2_n), .act_n(act_n),
        .ras_n(ras_n), .cas_n(cas_n), .we_n(we_n), .bg(bg), .ba(ba),
        .addr(addr), .dq_in(dq_in), .dq_out(dq2_out), .dq_oe(dq2_oe),
        .dqs_oe(dqs2_oe), .wr_done(wr2_done), .cmd_err(cmd2_err)
    );

    // Drives one command for a single clock; returns just after its sampling edge.
    task automatic cmd(input int kind, input logic [3:0] bank, input logic [17:0] a, input bit sel2);
        @(negedge clock);
        bg    = bank[3:2];
        ba    = bank[1:0];
        addr  = a;
        act_n = (kind != K_ACT);
        ras_n = (kind != K_PRE);
        cas_n = !(kind == K_RD || kind == K_WR);
        we_n  = !(kind == K_WR || kind == K_PRE);
        if (sel2) cs2_n = 1'b0;
        else      cs_n  = 1'b0;
        @(posedge clock);
        #1;
        cs_n = 1'b1; cs2_n = 1'b1;
        act_n = 1'b1; ras_n = 1'b1; cas_n = 1'b1; we_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        total++; if (dq_out !== 16'h0) begin bad++; $display("FAIL reset_dq_out got=%h want=0000", dq_out); end
        total++; if (dq_oe !== 1'b0)   begin bad++; $display("FAIL reset_dq_oe got=%b want=0", dq_oe); end
        total++; if (dqs_oe !== 1'b0)  begin bad++; $display("FAIL reset_dqs_oe got=%b want=0", dqs_oe); end
        total++; if (wr_done !== 1'b0) begin bad++; $display("FAIL reset_wr_done got=%b want=0", wr_done); end
        total++; if (cmd_err !== 1'b0) begin bad++; $display("FAIL reset_cmd_err got=%b want=0", cmd_err); end
        reset_n = 1'b1;
        repeat (2) @(negedge clock);
    endtask

    task automatic test_write_read();
        logic want_oe, want_dqs;
        logic [15:0] want_dq;
        cmd(K_ACT, 4'd1, 18'h3, 1'b0);
        @(negedge clock);
        total++; if (cmd_err !== 1'b0) begin bad++; $display("FAIL act_err got=%b want=0", cmd_err); end
        cmd(K_WR, 4'd1, 18'h10, 1'b0);
        for (int c = 0; c <= 16; c++) begin
            @(negedge clock);
            dq_in = (c >= 9 && c <= 12) ? exp_a[c-9] : 16'h0;
            if (c == 0) begin
                total++; if (cmd_err !== 1'b0) begin bad++; $display("FAIL wr_err got=%b want=0", cmd_err); end
            end
            total++;
            if (wr_done !== (c == 14)) begin bad++; $display("FAIL wr_done c=%0d got=%b want=%b", c, wr_done, c == 14); end
        end
        cmd(K_RD, 4'd1, 18'h10, 1'b0);
        for (int c = 0; c <= 19; c++) begin
            @(negedge clock);
            want_oe  = (c >= 13 && c <= 16);
            want_dqs = (c >= 12 && c <= 16);
            want_dq  = want_oe ? exp_a[c-13] : 16'h0;
            total++; if (dq_oe !== want_oe)   begin bad++; $display("FAIL rd_oe c=%0d got=%b want=%b", c, dq_oe, want_oe); end
            total++; if (dqs_oe !== want_dqs) begin bad++; $display("FAIL rd_dqs c=%0d got=%b want=%b", c, dqs_oe, want_dqs); end
            total++; if (dq_out !== want_dq)  begin bad++; $display("FAIL rd_data c=%0d got=%h want=%h", c, dq_out, want_dq); end
        end
    endtask

    task automatic test_closed_bank();
        cmd(K_RD, 4'd5, 18'h10, 1'b0);
        for (int c = 0; c <= 16; c++) begin
            @(negedge clock);
            total++; if (cmd_err !== (c == 0)) begin bad++; $display("FAIL closed_err c=%0d got=%b want=%b", c, cmd_err, c == 0); end
            total++; if (dq_oe !== 1'b0)       begin bad++; $display("FAIL closed_oe c=%0d got=%b want=0", c, dq_oe); end
        end
    endtask

    task automatic test_back_to_back();
        logic want_oe;
        logic [15:0] want_dq;
        // tCCD spacing: seamless 8 data clocks; second command uses an ignored burst offset
        cmd(K_RD, 4'd1, 18'h10, 1'b0);
        repeat (3) @(posedge clock);
        #1;
        cmd(K_RD, 4'd1, 18'h14, 1'b0);
        for (int c = 0; c <= 20; c++) begin
            @(negedge clock);
            want_oe = (c >= 9 && c <= 16);
            want_dq = want_oe ? exp_a[(c-9) % 4] : 16'h0;
            total++; if (cmd_err !== 1'b0)   begin bad++; $display("FAIL b2b_err c=%0d got=%b want=0", c, cmd_err); end
            total++; if (dq_oe !== want_oe)  begin bad++; $display("FAIL b2b_oe c=%0d got=%b want=%b", c, dq_oe, want_oe); end
            total++; if (dq_out !== want_dq) begin bad++; $display("FAIL b2b_data c=%0d got=%h want=%h", c, dq_out, want_dq); end
        end
        // Two clocks apart: the second read overlaps and is dropped
        cmd(K_RD, 4'd1, 18'h10, 1'b0);
        @(posedge clock);
        #1;
        cmd(K_RD, 4'd1, 18'h10, 1'b0);
        for (int c = 0; c <= 18; c++) begin
            @(negedge clock);
            want_oe = (c >= 11 && c <= 14);
            total++; if (cmd_err !== (c == 0)) begin bad++; $display("FAIL rr2_err c=%0d got=%b want=%b", c, cmd_err, c == 0); end
            total++; if (dq_oe !== want_oe)    begin bad++; $display("FAIL rr2_oe c=%0d got=%b want=%b", c, dq_oe, want_oe); end
        end
        // Write whose data window lands on the read's data clocks is dropped
        cmd(K_RD, 4'd1, 18'h10, 1'b0);
        repeat (2) @(posedge clock);
        #1;
        cmd(K_WR, 4'd1, 18'h10, 1'b0);
        for (int c = 0; c <= 18; c++) begin
            @(negedge clock);
            want_oe = (c >= 10 && c <= 13);
            total++; if (cmd_err !== (c == 0)) begin bad++; $display("FAIL rw_err c=%0d got=%b want=%b", c, cmd_err, c == 0); end
            total++; if (dq_oe !== want_oe)    begin bad++; $display("FAIL rw_oe c=%0d got=%b want=%b", c, dq_oe, want_oe); end
            total++; if (wr_done !== 1'b0)     begin bad++; $display("FAIL rw_wr_done c=%0d got=%b want=0", c, wr_done); end
        end
    endtask

    task automatic test_act_open();
        logic want_oe;
        logic [15:0] want_dq;
        cmd(K_ACT, 4'd1, 18'h5, 1'b0);
        @(negedge clock);
        total++; if (cmd_err !== 1'b1) begin bad++; $display("FAIL act_open_err got=%b want=1", cmd_err); end
        @(negedge clock);
        total++; if (cmd_err !== 1'b0) begin bad++; $display("FAIL act_open_pulse got=%b want=0", cmd_err); end
        cmd(K_RD, 4'd1, 18'h10, 1'b0);
        for (int c = 0; c <= 17; c++) begin
            @(negedge clock);
            want_oe = (c >= 13 && c <= 16);
            want_dq = want_oe ? exp_a[c-13] : 16'h0;
            total++; if (dq_out !== want_dq) begin bad++; $display("FAIL act_row_kept c=%0d got=%h want=%h", c, dq_out, want_dq); end
        end
        cmd(K_PRE, 4'd1, 18'h0, 1'b0);
        @(negedge clock);
        total++; if (cmd_err !== 1'b0) begin bad++; $display("FAIL pre_err got=%b want=0", cmd_err); end
        cmd(K_RD, 4'd1, 18'h10, 1'b0);
        @(negedge clock);
        total++; if (cmd_err !== 1'b1) begin bad++; $display("FAIL rd_after_pre got=%b want=1", cmd_err); end
        cmd(K_PRE, 4'd1, 18'h0, 1'b0);
        @(negedge clock);
        total++; if (cmd_err !== 1'b0) begin bad++; $display("FAIL pre_closed got=%b want=0", cmd_err); end
        cmd(K_ACT, 4'd1, 18'h3, 1'b0);
        @(negedge clock);
        total++; if (cmd_err !== 1'b0) begin bad++; $display("FAIL reopen_err got=%b want=0", cmd_err); end
    endtask

    task automatic test_al();
        logic want_oe;
        logic [15:0] want_dq;
        cmd(K_ACT, 4'd1, 18'h3, 1'b1);
        @(negedge clock);
        total++; if (cmd2_err !== 1'b0) begin bad++; $display("FAIL al_act_err got=%b want=0", cmd2_err); end
        cmd(K_WR, 4'd1, 18'h10, 1'b1);
        for (int c = 0; c <= 18; c++) begin
            @(negedge clock);
            dq_in = (c >= 11 && c <= 14) ? exp_b[c-11] : 16'h0;
            total++;
            if (wr2_done !== (c == 16)) begin bad++; $display("FAIL al_wr_done c=%0d got=%b want=%b", c, wr2_done, c == 16); end
        end
        cmd(K_RD, 4'd1, 18'h10, 1'b1);
        for (int c = 0; c <= 21; c++) begin
            @(negedge clock);
            want_oe = (c >= 15 && c <= 18);
            want_dq = want_oe ? exp_b[c-15] : 16'h0;
            total++; if (dq2_oe !== want_oe)   begin bad++; $display("FAIL al_oe c=%0d got=%b want=%b", c, dq2_oe, want_oe); end
            total++; if (dqs2_oe !== want_oe)  begin bad++; $display("FAIL al_dqs c=%0d got=%b want=%b", c, dqs2_oe, want_oe); end
            total++; if (dq2_out !== want_dq)  begin bad++; $display("FAIL al_data c=%0d got=%h want=%h", c, dq2_out, want_dq); end
        end
    endtask

    task automatic test_reset_mid();
        logic want_oe;
        logic [15:0] want_dq;
        cmd(K_RD, 4'd1, 18'h10, 1'b0);
        for (int c = 0; c <= 14; c++) begin
            @(negedge clock);
            if (c == 13) begin
                total++; if (dq_oe !== 1'b1) begin bad++; $display("FAIL mid_d0_oe got=%b want=1", dq_oe); end
            end
            if (c == 14) begin
                total++; if (dq_out !== exp_a[1]) begin bad++; $display("FAIL mid_d1_data got=%h want=%h", dq_out, exp_a[1]); end
                reset_n = 1'b0;
                #1;
                total++; if (dq_oe !== 1'b0)    begin bad++; $display("FAIL mid_rst_oe got=%b want=0", dq_oe); end
                total++; if (dqs_oe !== 1'b0)   begin bad++; $display("FAIL mid_rst_dqs got=%b want=0", dqs_oe); end
                total++; if (dq_out !== 16'h0)  begin bad++; $display("FAIL mid_rst_dq got=%h want=0000", dq_out); end
            end
        end
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        for (int c = 0; c <= 5; c++) begin
            @(negedge clock);
            total++; if (dq_oe !== 1'b0) begin bad++; $display("FAIL post_rst_oe c=%0d got=%b want=0", c, dq_oe); end
        end
        cmd(K_RD, 4'd1, 18'h10, 1'b0);
        @(negedge clock);
        total++; if (cmd_err !== 1'b1) begin bad++; $display("FAIL post_rst_closed got=%b want=1", cmd_err); end
        cmd(K_ACT, 4'd1, 18'h3, 1'b0);
        cmd(K_RD, 4'd1, 18'h10, 1'b0);
        for (int c = 0; c <= 17; c++) begin
            @(negedge clock);
            want_oe = (c >= 13 && c <= 16);
            want_dq = want_oe ? exp_a[c-13] : 16'h0;
            total++; if (dq_oe !== want_oe)  begin bad++; $display("FAIL kept_oe c=%0d got=%b want=%b", c, dq_oe, want_oe); end
            total++; if (dq_out !== want_dq) begin bad++; $display("FAIL kept_data c=%0d got=%h want=%h", c, dq_out, want_dq); end
        end
    endtask

    task automatic test_pre_all();
        cmd(K_ACT, 4'd6, 18'h2, 1'b0);
        @(negedge clock);
        total++; if (cmd_err !== 1'b0) begin bad++; $display("FAIL act6_err got=%b want=0", cmd_err); end
        cmd(K_PRE, 4'd3, 18'h400, 1'b0);
        @(negedge clock);
        total++; if (cmd_err !== 1'b0) begin bad++; $display("FAIL preall_err got=%b want=0", cmd_err); end
        cmd(K_WR, 4'd1, 18'h10, 1'b0);
        @(negedge clock);
        total++; if (cmd_err !== 1'b1) begin bad++; $display("FAIL preall_wr1 got=%b want=1", cmd_err); end
        cmd(K_WR, 4'd6, 18'h10, 1'b0);
        @(negedge clock);
        total++; if (cmd_err !== 1'b1) begin bad++; $display("FAIL preall_wr6 got=%b want=1", cmd_err); end
        for (int c = 0; c <= 16; c++) begin
            @(negedge clock);
            total++; if (wr_done !== 1'b0) begin bad++; $display("FAIL preall_done c=%0d got=%b want=0", c, wr_done); end
        end
    endtask

    initial begin
        exp_a[0] = 16'h0201; exp_a[1] = 16'h0403; exp_a[2] = 16'h0605; exp_a[3] = 16'h0807;
        exp_b[0] = 16'h1211; exp_b[1] = 16'h1413; exp_b[2] = 16'h1615; exp_b[3] = 16'h1817;
        test_reset();
        test_write_read();
        test_closed_bank();
        test_back_to_back();
        test_act_open();
        test_al();
        test_reset_mid();
        test_pre_all();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
